// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : hazard_controller
// Description : Pipeline hazard sequencer for the 5-stage RV32 core. Detects
//               load-use, ID-stage branch operand hazards and memory-busy
//               freezes; drives pipeline enables, bubble and flush; counts
//               stall and flush cycles with saturating counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_is_branch,
    input  logic [4:0]       idex_rd,
    input  logic             idex_rw,
    input  logic             idex_mr,
    input  logic [4:0]       exmem_rd,
    input  logic             exmem_mr,
    input  logic             mispredict,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             pipe_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_STALL2 = 1'b1
    } state_t;

    state_t r_state;

    logic w_hit_ex;
    logic w_hit_mem;
    logic w_lu;
    logic w_ba;
    logic w_bl;
    logic w_bm;
    logic w_hazard;

    // Register-match detection against the ID/EX and EX/MEM destinations; x0 never matches
    always_comb begin
        w_hit_ex  = (id_use_rs1 && (idex_rd != 5'd0) && (id_rs1 == idex_rd)) ||
                    (id_use_rs2 && (idex_rd != 5'd0) && (id_rs2 == idex_rd));
        w_hit_mem = (id_use_rs1 && (exmem_rd != 5'd0) && (id_rs1 == exmem_rd)) ||
                    (id_use_rs2 && (exmem_rd != 5'd0) && (id_rs2 == exmem_rd));
        w_lu      = !id_is_branch && idex_mr && w_hit_ex;
        w_ba      = id_is_branch && idex_rw && !idex_mr && w_hit_ex;
        w_bl      = id_is_branch && idex_mr && w_hit_ex;
        w_bm      = id_is_branch && exmem_mr && w_hit_mem;
        w_hazard  = w_lu || w_ba || w_bl || w_bm;
    end

    // Output decode: reset and memory freeze dominate, then stalls, then flush
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        pipe_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        if (rst || mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_write = 1'b0;
        end else if ((r_state == ST_STALL2) || w_hazard) begin
            // Mispredict is deliberately ignored here; the branch re-resolves after the stall
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (mispredict) begin
            ifid_flush = 1'b1;
        end
    end

    // Stall sequencing FSM and saturating performance counters; all frozen by mem_busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!mem_busy) begin
            case (r_state)
                ST_RUN:    r_state <= w_bl ? ST_STALL2 : ST_RUN;
                ST_STALL2: r_state <= ST_RUN;
                default:   r_state <= ST_RUN;
            endcase
            if (idex_bubble && (stall_cnt != c_CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (ifid_flush && (flush_cnt != c_CNT_MAX)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_controller
// Description : Randomized scoreboard bench for hazard_controller. A driver
//               applies stimulus and queues the response predicted by a
//               cycle-count reference model; a monitor compares each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_controller;

    typedef struct packed {
        logic       r;
        logic       mb;
        logic       mp;
        logic       br;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] xrd;
        logic       xrw;
        logic       xmr;
        logic [4:0] mrd;
        logic       mmr;
    } stim_t;

    typedef struct packed {
        logic        pcw;
        logic        ifw;
        logic        pw;
        logic        bub;
        logic        fl;
        logic [15:0] sc;
        logic [15:0] fc;
        logic [2:0]  ssc;
        logic [2:0]  sfc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, idex_rd, exmem_rd;
    logic        id_use_rs1, id_use_rs2, id_is_branch, idex_rw, idex_mr, exmem_mr;
    logic        mispredict, mem_busy;
    logic        pc_write, ifid_write, pipe_write, idex_bubble, ifid_flush;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_pcw, s_ifw, s_pw, s_bub, s_fl;
    logic [2:0]  s_stall_cnt, s_flush_cnt;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: forced stall cycles still owed, plus counter totals
    int m_pend = 0;
    int m_sc = 0, m_fc = 0, m_ssc = 0, m_sfc = 0;

    always #5 clk = ~clk;

    hazard_controller #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_is_branch(id_is_branch),
        .idex_rd(idex_rd), .idex_rw(idex_rw), .idex_mr(idex_mr),
        .exmem_rd(exmem_rd), .exmem_mr(exmem_mr),
        .mispredict(mispredict), .mem_busy(mem_busy),
        .pc_write(pc_write), .ifid_write(ifid_write), .pipe_write(pipe_write),
        .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter instance so saturation is reached within a short run
    hazard_controller #(.CNT_W(3)) dut_small (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_is_branch(id_is_branch),
        .idex_rd(idex_rd), .idex_rw(idex_rw), .idex_mr(idex_mr),
        .exmem_rd(exmem_rd), .exmem_mr(exmem_mr),
        .mispredict(mispredict), .mem_busy(mem_busy),
        .pc_write(s_pcw), .ifid_write(s_ifw), .pipe_write(s_pw),
        .idex_bubble(s_bub), .ifid_flush(s_fl),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    function automatic bit hit(input stim_t s, input logic [4:0] rd);
        return (s.u1 && rs_ok(s.rs1) && s.rs1 == rd) || (s.u2 && rs_ok(s.rs2) && s.rs2 == rd);
    endfunction

    function automatic bit rs_ok(input logic [4:0] r);
        return r != 5'd0;
    endfunction

    // Stall cycles the ID instruction needs before its operands are obtainable
    function automatic int need(input stim_t s);
        int n = 0;
        if (!s.br) begin
            if (s.xmr && hit(s, s.xrd)) n = 1;
        end else begin
            if (s.xmr && hit(s, s.xrd))      n = 2;
            else if (s.xrw && hit(s, s.xrd)) n = 1;
            if (s.mmr && hit(s, s.mrd) && n < 1) n = 1;
        end
        return n;
    endfunction

    // Apply one cycle of stimulus just after the rising edge and queue the prediction
    task automatic run(input stim_t s);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        rst = s.r; mem_busy = s.mb; mispredict = s.mp; id_is_branch = s.br;
        id_rs1 = s.rs1; id_rs2 = s.rs2; id_use_rs1 = s.u1; id_use_rs2 = s.u2;
        idex_rd = s.xrd; idex_rw = s.xrw; idex_mr = s.xmr;
        exmem_rd = s.mrd; exmem_mr = s.mmr;
        e = '0;
        if (s.r) begin
            m_pend = 0; m_sc = 0; m_fc = 0; m_ssc = 0; m_sfc = 0;
        end
        e.sc = 16'(m_sc); e.fc = 16'(m_fc); e.ssc = 3'(m_ssc); e.sfc = 3'(m_sfc);
        if (!s.r && !s.mb) begin
            n = need(s);
            if (m_pend > 0 || n > 0) begin
                e.pw = 1'b1; e.bub = 1'b1;
                if (m_pend > 0) m_pend--;
                else            m_pend = n - 1;
                if (m_sc < 65535) m_sc++;
                if (m_ssc < 7)    m_ssc++;
            end else begin
                e.pcw = 1'b1; e.ifw = 1'b1; e.pw = 1'b1;
                if (s.mp) begin
                    e.fl = 1'b1;
                    if (m_fc < 65535) m_fc++;
                    if (m_sfc < 7)    m_sfc++;
                end
            end
        end
        q.push_back(e);
    endtask

    // Monitor: the DUT presents a response every cycle; compare mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_write",    int'(pc_write),    int'(e.pcw));
                chk("ifid_write",  int'(ifid_write),  int'(e.ifw));
                chk("pipe_write",  int'(pipe_write),  int'(e.pw));
                chk("idex_bubble", int'(idex_bubble), int'(e.bub));
                chk("ifid_flush",  int'(ifid_flush),  int'(e.fl));
                chk("stall_cnt",   int'(stall_cnt),   int'(e.sc));
                chk("flush_cnt",   int'(flush_cnt),   int'(e.fc));
                chk("stall_cnt_w3", int'(s_stall_cnt), int'(e.ssc));
                chk("flush_cnt_w3", int'(s_flush_cnt), int'(e.sfc));
            end
        end
    end

    initial begin
        stim_t s, z, lu, bl;
        rst = 1'b1; mem_busy = 1'b0; mispredict = 1'b0; id_is_branch = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        idex_rd = '0; idex_rw = 1'b0; idex_mr = 1'b0; exmem_rd = '0; exmem_mr = 1'b0;
        z = '0;
        s = z; s.r = 1'b1;
        run(s); run(s);
        // Load-use via rs2, then a normal cycle
        lu = z; lu.xrd = 5'd5; lu.xmr = 1'b1; lu.xrw = 1'b1; lu.rs2 = 5'd5; lu.u2 = 1'b1;
        run(lu); run(z);
        // Branch on a load result: two stalls, second with idex cleared and a mispredict
        bl = z; bl.br = 1'b1; bl.xrd = 5'd7; bl.xmr = 1'b1; bl.xrw = 1'b1; bl.rs1 = 5'd7; bl.u1 = 1'b1;
        run(bl);
        s = z; s.br = 1'b1; s.rs1 = 5'd7; s.u1 = 1'b1; s.mp = 1'b1;
        run(s); run(z);
        // x0 never matches; load in MEM read by a branch stalls once
        s = z; s.br = 1'b1; s.xrd = 5'd0; s.xrw = 1'b1; s.u1 = 1'b1; s.u2 = 1'b1;
        run(s);
        s = z; s.br = 1'b1; s.mrd = 5'd3; s.mmr = 1'b1; s.rs2 = 5'd3; s.u2 = 1'b1;
        run(s); run(z);
        // Mispredict with no hazard flushes once
        s = z; s.mp = 1'b1;
        run(s); run(z);
        // Memory freeze in the second branch-load stall
        run(bl);
        s = z; s.mb = 1'b1; s.mp = 1'b1;
        run(s); run(s); run(s);
        run(z); run(z);
        // Reset in the middle of the second stall
        run(bl);
        s = z; s.r = 1'b1;
        run(s); run(z);
        // Repeated load-use stalls drive the narrow counter into saturation
        repeat (10) run(lu);
        s = z; s.mp = 1'b1;
        repeat (9) run(s);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            s.r   = ($urandom_range(0, 99) == 0);
            s.mb  = ($urandom_range(0, 5) == 0);
            s.mp  = ($urandom_range(0, 3) == 0);
            s.br  = 1'($urandom_range(0, 1));
            s.rs1 = 5'($urandom_range(0, 3));
            s.rs2 = 5'($urandom_range(0, 3));
            s.u1  = 1'($urandom_range(0, 1));
            s.u2  = 1'($urandom_range(0, 1));
            s.xrd = 5'($urandom_range(0, 3));
            s.xrw = 1'($urandom_range(0, 1));
            s.xmr = 1'($urandom_range(0, 1));
            s.mrd = 5'($urandom_range(0, 3));
            s.mmr = 1'($urandom_range(0, 1));
            run(s);
        end
        repeat (3) @(negedge clk);
        chk("queue_drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
